ddrio_lvds_tx_framer: RTL

Transmit-side framer for the two-pad DDR LVDS I/O pair: accepts a byte stream with valid/ready/last and drives the per-pad DDR output bits (odp/odn) and output enables of the paired I/O cell each clock. Frames are bracketed by a preamble, a sync byte and a one-cycle postamble, and the pads are released to receive (oen high) between frames. It is the transmitting counterpart of the DDR receive path, which samples idp/idn per pad on the same clock.

---
 rtl/ddrio_tx_pkg.sv | 42 ++++
 rtl/ddrio_lvds_tx_framer_if.sv | 18 +
 rtl/ddrio_tx_crc8.sv | 33 +++
 rtl/ddrio_lvds_tx_framer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ddrio_tx_pkg.sv
// ============================================================================
// Module      : ddrio_tx_pkg
// Description : Shared types and constants for the DDR LVDS transmit framer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ddrio_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SYNC     = 3'd2,
        ST_DATA     = 3'd3,
        ST_CRC      = 3'd4,
        ST_POST     = 3'd5
    } tx_state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hB8;
    localparam logic [7:0] CRC_POLY          = 8'h07;

    // Bit positions inside the nibble presented on one clock.
    localparam int PAD0_P_BIT = 3;
    localparam int PAD0_N_BIT = 2;
    localparam int PAD1_P_BIT = 1;
    localparam int PAD1_N_BIT = 0;

    // Both pads drive p=1, n=0 during the preamble.
    localparam logic [3:0] PREAMBLE_NIBBLE = 4'b1010;

    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ddrio_lvds_tx_framer_if.sv
// ============================================================================
// Module      : ddrio_lvds_tx_framer_if
// Description : Byte stream (data/valid/last/ready) into the transmit framer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ddrio_lvds_tx_framer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (output s_data, output s_valid, output s_last, input s_ready);
    modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

`default_nettype wire

// File: rtl/ddrio_tx_crc8.sv
// ============================================================================
// Module      : ddrio_tx_crc8
// Description : Byte-wide CRC-8 (poly 0x07, init 0) accumulator with clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddrio_tx_crc8
    import ddrio_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic [7:0] i_data,
    output logic [7:0] o_crc
);

    logic [7:0] r_crc;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_crc <= 8'h00;
        end else if (i_en) begin
            r_crc <= crc8_next(r_crc, i_data);
        end
    end

    assign o_crc = r_crc;

endmodule

`default_nettype wire

// File: rtl/ddrio_lvds_tx_framer.sv
// ============================================================================
// Module      : ddrio_lvds_tx_framer
// Description : Frames a byte stream onto a two-pad DDR LVDS pair with
//               preamble, sync byte and postamble. Optional CRC-8 trailer
//               when DDRIO_TX_CRC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddrio_lvds_tx_framer
    import ddrio_tx_pkg::*;
#(
    parameter int         PREAMBLE_CYCLES = 4,
    parameter logic [7:0] SYNC_BYTE       = DEFAULT_SYNC_BYTE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tx_en,
    ddrio_lvds_tx_framer_if.slave  strm,
    output logic                   odp0,
    output logic                   odn0,
    output logic                   odp1,
    output logic                   odn1,
    output logic                   oen0,
    output logic                   oen1,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   err_underrun
);

    localparam logic [3:0] c_pre_last = 4'(PREAMBLE_CYCLES);

    tx_state_t  r_state, w_state_nxt;
    logic       r_phase, w_phase_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_byte, w_byte_nxt;
    logic       r_last_taken, w_last_nxt;

    logic [3:0] r_nib, w_nib_nxt;
    logic       r_oen, w_oen_nxt;
    logic       r_ready, w_ready_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_done, w_done_nxt;
    logic       r_undr, w_undr_nxt;

    logic       w_accept;
    logic       w_underrun;

    assign w_accept   = r_ready && strm.s_valid;
    assign w_underrun = r_ready && !strm.s_valid;

`ifdef DDRIO_TX_CRC_EN
    logic [7:0] w_crc;

    ddrio_tx_crc8 u_crc (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (r_state == ST_IDLE),
        .i_en   (w_accept),
        .i_data (strm.s_data),
        .o_crc  (w_crc)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_phase      <= 1'b0;
            r_cnt        <= 4'd0;
            r_byte       <= 8'h00;
            r_last_taken <= 1'b0;
            r_nib        <= 4'h0;
            r_oen        <= 1'b1;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_undr       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_phase      <= w_phase_nxt;
            r_cnt        <= w_cnt_nxt;
            r_byte       <= w_byte_nxt;
            r_last_taken <= w_last_nxt;
            r_nib        <= w_nib_nxt;
            r_oen        <= w_oen_nxt;
            r_ready      <= w_ready_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_undr       <= w_undr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        w_byte_nxt  = r_byte;
        w_last_nxt  = r_last_taken;
        w_done_nxt  = 1'b0;
        w_undr_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_phase_nxt = 1'b0;
                w_last_nxt  = 1'b0;
                w_cnt_nxt   = 4'd1;
                if (tx_en && strm.s_valid) begin
                    w_state_nxt = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                if (r_cnt == c_pre_last) begin
                    w_state_nxt = ST_SYNC;
                    w_byte_nxt  = SYNC_BYTE;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            ST_SYNC, ST_DATA: begin
                w_phase_nxt = ~r_phase;
                if (r_phase) begin
                    if (w_accept) begin
                        w_state_nxt = ST_DATA;
                        w_byte_nxt  = strm.s_data;
                        w_last_nxt  = strm.s_last;
                    end else if (w_underrun) begin
                        w_state_nxt = ST_POST;
                        w_undr_nxt  = 1'b1;
                    end else begin
                        // Only reachable once the last byte has been fully sent.
`ifdef DDRIO_TX_CRC_EN
                        w_state_nxt = ST_CRC;
                        w_byte_nxt  = w_crc;
`else
                        w_state_nxt = ST_POST;
                        w_done_nxt  = 1'b1;
`endif
                    end
                end
            end
`ifdef DDRIO_TX_CRC_EN
            ST_CRC: begin
                w_phase_nxt = ~r_phase;
                if (r_phase) begin
                    w_state_nxt = ST_POST;
                    w_done_nxt  = 1'b1;
                end
            end
`endif
            ST_POST: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Output registers are loaded from the next state so they line up with it.
        w_nib_nxt = 4'h0;
        if (w_state_nxt == ST_PREAMBLE) begin
            w_nib_nxt = PREAMBLE_NIBBLE;
        end else if (w_state_nxt == ST_SYNC || w_state_nxt == ST_DATA || w_state_nxt == ST_CRC) begin
            w_nib_nxt = w_phase_nxt ? w_byte_nxt[3:0] : w_byte_nxt[7:4];
        end
        w_oen_nxt   = (w_state_nxt == ST_IDLE);
        w_busy_nxt  = (w_state_nxt != ST_IDLE);
        w_ready_nxt = (w_state_nxt == ST_SYNC || w_state_nxt == ST_DATA) && w_phase_nxt && !w_last_nxt;
    end

    assign odp0         = r_nib[PAD0_P_BIT];
    assign odn0         = r_nib[PAD0_N_BIT];
    assign odp1         = r_nib[PAD1_P_BIT];
    assign odn1         = r_nib[PAD1_N_BIT];
    assign oen0         = r_oen;
    assign oen1         = r_oen;
    assign strm.s_ready = r_ready;
    assign busy         = r_busy;
    assign frame_done   = r_done;
    assign err_underrun = r_undr;

endmodule

`default_nettype wire
